fdiv_mul: RTL



---
 rtl/fdiv_mul.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fdiv_mul.sv
// Final stage of single-precision division: y = x1 * (1/x2). Aligns x1 and the
// operand special-case info with the reciprocal unit's latency, then multiplies in two stages.
module fdiv_mul #(
    parameter int LAT_INV = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] inv,
    output logic        out_valid,
    output logic [31:0] y,
    output logic        dz,
    output logic        ovf,
    output logic        udf
);

    // Handshake: valid-only pipeline with no backpressure. A slot is live when its
    // valid bit is set; every stage advances every cycle and bubbles pass straight through.

    typedef struct packed {
        logic x2sign;
        logic x1zero;
        logic x1inf;
        logic x2zero;
        logic x2inf;
    } spec_t;

    spec_t       in_spec;
    logic        dl_valid [LAT_INV];
    logic [31:0] dl_x1    [LAT_INV];
    spec_t       dl_spec  [LAT_INV];

    logic        tail_valid;
    logic [31:0] tail_x1;
    spec_t       tail_spec;

    logic        m1_valid;
    logic        m1_sign;
    logic        m1_ssign;
    logic [47:0] m1_p;
    logic [9:0]  m1_exp;
    spec_t       m1_spec;

    logic [9:0]  exp_sum;
    logic [47:0] mant_a;
    logic [47:0] mant_b;

    logic signed [9:0] exp_n;
    logic [22:0] mant_n;
    logic [31:0] y_nxt;
    logic        dz_nxt;
    logic        ovf_nxt;
    logic        udf_nxt;

    always_comb begin
        in_spec.x2sign = x2[31];
        in_spec.x1zero = (x1[30:23] == 8'h00);
        in_spec.x1inf  = (x1[30:23] == 8'hFF);
        in_spec.x2zero = (x2[30:23] == 8'h00);
        in_spec.x2inf  = (x2[30:23] == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT_INV; i++) dl_valid[i] <= 1'b0;
        end else begin
            dl_valid[0] <= in_valid;
            for (int i = 1; i < LAT_INV; i++) dl_valid[i] <= dl_valid[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_x1[0]   <= x1;
        dl_spec[0] <= in_spec;
        for (int i = 1; i < LAT_INV; i++) begin
            dl_x1[i]   <= dl_x1[i-1];
            dl_spec[i] <= dl_spec[i-1];
        end
    end

    assign tail_valid = dl_valid[LAT_INV-1];
    assign tail_x1    = dl_x1[LAT_INV-1];
    assign tail_spec  = dl_spec[LAT_INV-1];

    assign exp_sum = {2'b00, tail_x1[30:23]} + {2'b00, inv[30:23]} - 10'd127;
    assign mant_a  = {24'd0, 1'b1, tail_x1[22:0]};
    assign mant_b  = {24'd0, 1'b1, inv[22:0]};

    always_ff @(posedge clk) begin
        if (!rstn) m1_valid <= 1'b0;
        else       m1_valid <= tail_valid;
    end

    always_ff @(posedge clk) begin
        if (tail_valid) begin
            m1_sign  <= tail_x1[31] ^ inv[31];
            m1_ssign <= tail_x1[31] ^ tail_spec.x2sign;
            m1_p     <= mant_a * mant_b;
            m1_exp   <= exp_sum;
            m1_spec  <= tail_spec;
        end
    end

    // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the extra shift.
    always_comb begin
        exp_n   = $signed(m1_exp) + $signed({9'd0, m1_p[47]});
        mant_n  = m1_p[47] ? m1_p[46:24] : m1_p[45:23];
        y_nxt   = {m1_sign, exp_n[7:0], mant_n};
        dz_nxt  = 1'b0;
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
        if ((m1_spec.x1zero && m1_spec.x2zero) || (m1_spec.x1inf && m1_spec.x2inf)) begin
            y_nxt = 32'h7FC0_0000;
        end else if (m1_spec.x2zero) begin
            y_nxt  = {m1_ssign, 8'hFF, 23'd0};
            dz_nxt = 1'b1;
        end else if (m1_spec.x1inf) begin
            y_nxt = {m1_ssign, 8'hFF, 23'd0};
        end else if (m1_spec.x1zero || m1_spec.x2inf) begin
            y_nxt = {m1_ssign, 31'd0};
        end else if (exp_n >= 10'sd255) begin
            y_nxt   = {m1_sign, 8'hFF, 23'd0};
            ovf_nxt = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            y_nxt   = {m1_sign, 31'd0};
            udf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            y         <= 32'd0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            out_valid <= m1_valid;
            if (m1_valid) begin
                y   <= y_nxt;
                dz  <= dz_nxt;
                ovf <= ovf_nxt;
                udf <= udf_nxt;
            end
        end
    end

endmodule
